// File: rtl/tick_scheduler_if.sv
// Configuration/status bundle for tick_scheduler.
//   master : drives the cfg_* write strobe and fields, observes status
//   slave  : the scheduler, receives cfg_* and drives base/tick/busy/error
// Ports:
//   cfg_we_i, cfg_ch_i, cfg_en_i, cfg_oneshot_i, cfg_period_i  (master -> slave)
//   base_tick_o, tick_o, busy_o, cfg_err_o                     (slave -> master)
interface tick_scheduler_if #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int CHW = 2
);
    logic            cfg_we_i;
    logic [CHW-1:0]  cfg_ch_i;
    logic            cfg_en_i;
    logic            cfg_oneshot_i;
    logic [CW-1:0]   cfg_period_i;
    logic            base_tick_o;
    logic [NCH-1:0]  tick_o;
    logic [NCH-1:0]  busy_o;
    logic            cfg_err_o;

    modport master (
        output cfg_we_i, cfg_ch_i, cfg_en_i, cfg_oneshot_i, cfg_period_i,
        input  base_tick_o, tick_o, busy_o, cfg_err_o
    );

    modport slave (
        input  cfg_we_i, cfg_ch_i, cfg_en_i, cfg_oneshot_i, cfg_period_i,
        output base_tick_o, tick_o, busy_o, cfg_err_o
    );
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: one free-running prescaler shared by NCH tick channels.
// Each channel counts prescaler strobes and emits a registered one-cycle
// tick every 'period' strobes (periodic) or once (one-shot).
// Ports:
//   clk_i  system clock
//   rst_i  synchronous reset, active-high
//   bus    tick_scheduler_if.slave (cfg write port in, base/tick/busy/err out)
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | channel stopped, count held at 0, no ticks
// ST_RUN  | channel counting base-tick strobes toward period
module tick_scheduler #(
    parameter int PRESCALE = 1200,
    parameter int NCH      = 4,
    parameter int CW       = 16,
    parameter int CHW      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tick_scheduler_if.slave      bus
);
    localparam int PW = $clog2(PRESCALE);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    logic [PW-1:0]  r_pcnt;
    logic           r_base_tick;
    logic [NCH-1:0] r_tick;
    logic           r_err;
    logic [NCH-1:0] r_oneshot;
    state_t         r_state  [NCH];
    logic [CW-1:0]  r_cnt    [NCH];
    logic [CW-1:0]  r_period [NCH];

    logic           w_bt;
    logic           w_ch_ok;
    logic           w_bad_wr;
    logic [NCH-1:0] w_hit;
    logic [NCH-1:0] w_tick_nxt;
    logic [NCH-1:0] w_oneshot_nxt;
    logic [NCH-1:0] w_busy;
    logic           w_err_nxt;
    state_t         w_state_nxt  [NCH];
    logic [CW-1:0]  w_cnt_nxt    [NCH];
    logic [CW-1:0]  w_period_nxt [NCH];

    assign w_bt     = (r_pcnt == PW'(PRESCALE - 1));
    assign w_ch_ok  = (32'(bus.cfg_ch_i) < NCH);
    // A rejected write does not touch any channel, so it must not steal a strobe either.
    assign w_bad_wr = bus.cfg_we_i &&
                      (!w_ch_ok || (bus.cfg_en_i && (bus.cfg_period_i == '0)));

    always_comb begin
        w_err_nxt     = r_err | w_bad_wr;
        w_tick_nxt    = '0;
        w_oneshot_nxt = r_oneshot;
        w_hit         = '0;
        w_busy        = '0;
        for (int i = 0; i < NCH; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_cnt_nxt[i]    = r_cnt[i];
            w_period_nxt[i] = r_period[i];
            w_busy[i]       = (r_state[i] == ST_RUN);
            w_hit[i]        = bus.cfg_we_i && !w_bad_wr && (32'(bus.cfg_ch_i) == i);

            if (w_hit[i]) begin
                w_cnt_nxt[i] = '0;
                if (bus.cfg_en_i) begin
                    w_state_nxt[i]   = ST_RUN;
                    w_period_nxt[i]  = bus.cfg_period_i;
                    w_oneshot_nxt[i] = bus.cfg_oneshot_i;
                end else begin
                    w_state_nxt[i] = ST_IDLE;
                end
            end else if (r_state[i] == ST_RUN && w_bt) begin
                if (r_cnt[i] == r_period[i] - CW'(1)) begin
                    w_tick_nxt[i] = 1'b1;
                    w_cnt_nxt[i]  = '0;
                    if (r_oneshot[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pcnt      <= '0;
            r_base_tick <= 1'b0;
            r_tick      <= '0;
            r_err       <= 1'b0;
            r_oneshot   <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= ST_IDLE;
                r_cnt[i]    <= '0;
                r_period[i] <= '0;
            end
        end else begin
            r_pcnt      <= w_bt ? '0 : r_pcnt + PW'(1);
            r_base_tick <= w_bt;
            r_tick      <= w_tick_nxt;
            r_err       <= w_err_nxt;
            r_oneshot   <= w_oneshot_nxt;
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
                r_period[i] <= w_period_nxt[i];
            end
        end
    end

    assign bus.base_tick_o = r_base_tick;
    assign bus.tick_o      = r_tick;
    assign bus.busy_o      = w_busy;
    assign bus.cfg_err_o   = r_err;
endmodule
